// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - byte handshake between a producer and the UART transmit serializer
interface uart_tx_serializer_if #(
   parameter int DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] data_in;
   logic                 valid;
   logic                 ready;

   modport master (output data_in, output valid, input  ready);
   modport slave  (input  data_in, input  valid, output ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART frame serializer paced by an external baud_tick pulse
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bits.
module uart_tx_serializer #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_tick,
   uart_tx_serializer_if.slave  s,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);
   localparam int CW = $clog2(DATA_BITS + 1);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 ready_q;
   logic                 tx_d, ready_d, busy_d, done_d;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   assign s.ready = ready_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         tx       <= 1'b1;
         ready_q  <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         tx       <= tx_d;
         ready_q  <= ready_d;
         busy     <= busy_d;
         tx_done  <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (s.valid && ready_q) begin
               shift_d  = s.data_in;
`ifdef UART_TX_PARITY_EN
               parity_d = ^s.data_in;
`endif
               state_d  = ARM;
            end
         end
         // A tick on the transfer edge is seen while still IDLE, so ARM always waits a full period.
         ARM: begin
            if (baud_tick) state_d = START;
         end
         START: begin
            if (baud_tick) begin
               state_d = DATA;
               cnt_d   = '0;
            end
         end
         DATA: begin
            if (baud_tick) begin
               shift_d = shift_q >> 1;
               if (cnt_q == CW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_tick) begin
               state_d = STOP;
               cnt_d   = '0;
            end
         end
`endif
         STOP: begin
            if (baud_tick) begin
               if (cnt_q == CW'(STOP_BITS - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is derived from the next state so tx changes only on a register edge.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = parity_d;
`endif
         default: tx_d = 1'b1;
      endcase
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed bench for uart_tx_serializer (1 and 2 stop-bit instances)
module tb_uart_tx_serializer;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sel = 1'b0;
   logic       tick_drv = 1'b0;
   logic       valid_drv = 1'b0;
   logic [7:0] data_drv = 8'h00;
   logic       tick0, tick1;
   logic       tx0, busy0, done0, tx1, busy1, done1;
   logic       tx_o, busy_o, done_o, ready_o;
   int         checks = 0;
   int         errors = 0;

   uart_tx_serializer_if #(.DATA_BITS(8)) if0 ();
   uart_tx_serializer_if #(.DATA_BITS(8)) if1 ();

   assign if0.data_in = data_drv;
   assign if1.data_in = data_drv;
   assign if0.valid   = valid_drv & ~sel;
   assign if1.valid   = valid_drv & sel;
   assign tick0       = tick_drv & ~sel;
   assign tick1       = tick_drv & sel;
   assign tx_o        = sel ? tx1 : tx0;
   assign busy_o      = sel ? busy1 : busy0;
   assign done_o      = sel ? done1 : done0;
   assign ready_o     = sel ? if1.ready : if0.ready;

   uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1)) u0 (
      .clk(clk), .reset(reset), .baud_tick(tick0), .s(if0.slave),
      .tx(tx0), .busy(busy0), .tx_done(done0)
   );
   uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2)) u1 (
      .clk(clk), .reset(reset), .baud_tick(tick1), .s(if1.slave),
      .tx(tx1), .busy(busy1), .tx_done(done1)
   );

   always #5 clk = ~clk;

   // One frame: optional handshake, then per-bit level checks over every cycle of each bit period.
   task automatic run_frame(input string name, input logic [7:0] d, input int period,
                            input bit tick_on_xfer, input bit pre_armed,
                            input bit hold, input logic [7:0] nxt);
      logic exp_bits [0:15];
      int   n, nstop, k, rbad, early;
      nstop = sel ? 2 : 1;
      n = 0;
      exp_bits[n] = 1'b1; n++;
      exp_bits[n] = 1'b0; n++;
      for (int i = 0; i < 8; i++) begin exp_bits[n] = d[i]; n++; end
      if (PAR == 1) begin exp_bits[n] = ^d; n++; end
      for (int i = 0; i < nstop; i++) begin exp_bits[n] = 1'b1; n++; end
      if (!pre_armed) begin
         @(negedge clk);
         data_drv  = d;
         valid_drv = 1'b1;
      end
      tick_drv = tick_on_xfer;
      checks++;
      if (ready_o !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_before_xfer: got %b expected 1", name, ready_o);
      end
      @(posedge clk);
      k = 0; rbad = 0; early = 0;
      for (int b = 0; b < n; b++) begin
         int bad;
         bad = 0;
         for (int c = 0; c < period; c++) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
               valid_drv = hold;
               data_drv  = nxt;
            end
            tick_drv = (c == period - 1);
            if (tx_o !== exp_bits[b]) bad++;
            if (ready_o !== 1'b0 || busy_o !== 1'b1) rbad++;
            if (done_o !== 1'b0) early++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL %s bit%0d: tx wrong in %0d of %0d cycles, expected level %b",
                     name, b, bad, period, exp_bits[b]);
         end
      end
      @(negedge clk);
      tick_drv = (period == 1);
      checks++;
      if (done_o !== 1'b1 || tx_o !== 1'b1 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++;
         $display("FAIL %s frame_end: tx_done=%b tx=%b busy=%b ready=%b expected 1 1 0 1",
                  name, done_o, tx_o, busy_o, ready_o);
      end
      checks++;
      if (rbad != 0 || early != 0) begin
         errors++;
         $display("FAIL %s in_frame: %0d ready/busy errors, %0d early tx_done, expected 0 0",
                  name, rbad, early);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (tx0 !== 1'b1 || if0.ready !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: tx=%b ready=%b busy=%b tx_done=%b expected 1 1 0 0",
                  tx0, if0.ready, busy0, done0);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_frame_a5();
      sel = 1'b0;
      run_frame("a5_tick10", 8'hA5, 10, 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0) begin
         errors++;
         $display("FAIL a5_done_pulse_width: tx_done=%b expected 0", done0);
      end
   endtask

   task automatic test_tick_on_transfer();
      sel = 1'b0;
      run_frame("tick_at_xfer", 8'h5A, 10, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_back_to_back();
      sel = 1'b0;
      run_frame("b2b_00", 8'h00, 10, 1'b0, 1'b0, 1'b1, 8'hFF);
      run_frame("b2b_ff", 8'hFF, 10, 1'b0, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic test_stop2_tied();
      @(negedge clk);
      sel = 1'b1;
      run_frame("stop2_3c", 8'h3C, 1, 1'b1, 1'b0, 1'b0, 8'h00);
      tick_drv = 1'b0;
      @(negedge clk);
      sel = 1'b0;
   endtask

   task automatic test_parity();
      sel = 1'b0;
      run_frame("parity_07", 8'h07, 10, 1'b0, 1'b0, 1'b0, 8'h00);
      run_frame("parity_03", 8'h03, 10, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_reset_mid_data();
      int bad;
      sel = 1'b0;
      @(negedge clk);
      data_drv  = 8'hA5;
      valid_drv = 1'b1;
      tick_drv  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_drv = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre: tx=%b busy=%b expected 0 1", tx0, busy0);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (tx0 !== 1'b1 || if0.ready !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_async: tx=%b ready=%b busy=%b tx_done=%b expected 1 1 0 0",
                  tx0, if0.ready, busy0, done0);
      end
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (done0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
      end
      tick_drv = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rst_mid_after: %0d cycles with tx_done/tx/busy activity, expected 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_frame_a5();
      test_tick_on_transfer();
      test_back_to_back();
      test_stop2_tied();
      if (PAR == 1) test_parity();
      test_reset_mid_data();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
